// File: rtl/avalon_pio_ext_if.sv
// avalon_pio_ext_if: Avalon-MM slave bus bundle for the parallel I/O block
interface avalon_pio_ext_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  modport master(output address, chipselect, write_n, writedata, input readdata);
  modport slave(input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/avalon_pio_ext.sv
// avalon_pio_ext: Avalon-MM PIO with per-bit direction, edge capture, IRQ mask and atomic set/clear
module avalon_pio_ext #(
  parameter int          DATA_WIDTH  = 8,
  parameter logic [31:0] RESET_VALUE = 0,
  parameter logic [31:0] DIR_RESET   = 0,
  parameter int          EDGE_TYPE   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  avalon_pio_ext_if.slave       bus,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic [DATA_WIDTH-1:0] out_en,
  output logic                  irq
);
  localparam logic [DATA_WIDTH-1:0] RV = RESET_VALUE[DATA_WIDTH-1:0];
  localparam logic [DATA_WIDTH-1:0] DV = DIR_RESET[DATA_WIDTH-1:0];
  logic [DATA_WIDTH-1:0] data_out, dir, mask, edge_cap, in_s1, in_sync, prev;
  logic [DATA_WIDTH-1:0] wd, edge_det, clr, data_nxt, dir_nxt, mask_nxt, rd;
  logic wr;
  logic unused_wd;
  assign unused_wd = ^bus.writedata;
  assign wr = bus.chipselect & ~bus.write_n;
  assign wd = bus.writedata[DATA_WIDTH-1:0];
  assign out_port = data_out;
  assign out_en = dir;
  assign irq = |(edge_cap & mask);
  always_comb begin
    edge_det = EDGE_TYPE == 0 ? in_sync & ~prev : EDGE_TYPE == 1 ? ~in_sync & prev : in_sync ^ prev;
    data_nxt = !wr ? data_out : bus.address == 3'd0 ? wd : bus.address == 3'd4 ? data_out | wd :
               bus.address == 3'd5 ? data_out & ~wd : data_out;
    dir_nxt  = wr && bus.address == 3'd1 ? wd : dir;
    mask_nxt = wr && bus.address == 3'd2 ? wd : mask;
    clr      = wr && bus.address == 3'd3 ? wd : '0;
    rd = bus.address == 3'd0 ? (dir & data_out) | (~dir & in_sync) : bus.address == 3'd1 ? dir :
         bus.address == 3'd2 ? mask : bus.address == 3'd3 ? edge_cap : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out     <= RV;
      dir          <= DV;
      mask         <= '0;
      edge_cap     <= '0;
      in_s1        <= '0;
      in_sync      <= '0;
      prev         <= '0;
      bus.readdata <= '0;
    end else begin
      data_out     <= data_nxt;
      dir          <= dir_nxt;
      mask         <= mask_nxt;
      // a fresh edge wins over a same-cycle clear so no edge is ever lost
      edge_cap     <= (edge_cap & ~clr) | edge_det;
      in_s1        <= in_port;
      in_sync      <= in_s1;
      prev         <= in_sync;
      bus.readdata <= 32'(rd);
    end
  end
endmodule

// File: tb/tb_avalon_pio_ext.sv
// tb_avalon_pio_ext: directed table plus hand sequences for avalon_pio_ext (8-bit, rising edge)
module tb_avalon_pio_ext;
  logic clk = 0, reset = 1;
  logic [7:0] in_port = 0, out_port, out_en;
  logic irq;
  int checks = 0, errors = 0;
  avalon_pio_ext_if bus();
  avalon_pio_ext #(.DATA_WIDTH(8), .RESET_VALUE(0), .DIR_RESET(0), .EDGE_TYPE(0)) dut (
    .clk(clk), .reset(reset), .bus(bus), .in_port(in_port),
    .out_port(out_port), .out_en(out_en), .irq(irq));
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  wa;
    logic [31:0] wd;
    logic [2:0]  ra;
    logic [31:0] er;
    logic [7:0]  eo;
  } vec_t;
  vec_t vec [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.address = a;
    bus.writedata = d;
    bus.chipselect = 1;
    bus.write_n = 0;
    tick(1);
    bus.chipselect = 0;
    bus.write_n = 1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    bus.address = a;
    tick(1);
    d = bus.readdata;
  endtask

  logic [31:0] r;
  initial begin
    bus.address = 0;
    bus.writedata = 0;
    bus.chipselect = 0;
    bus.write_n = 1;
    tick(2);
    reset = 0;
    check("rst_out_port", 32'(out_port), 0);
    check("rst_out_en", 32'(out_en), 0);
    check("rst_irq", 32'(irq), 0);
    check("rst_readdata", bus.readdata, 0);
    rd(3, r);
    check("rst_edge", r, 0);

    in_port = 8'h3C;
    tick(4);
    vec[0]  = '{3'd1, 32'h0000_00F0, 3'd1, 32'h0000_00F0, 8'h00};
    vec[1]  = '{3'd0, 32'h0000_00A5, 3'd0, 32'h0000_00AC, 8'hA5};
    vec[2]  = '{3'd0, 32'h0000_0020, 3'd0, 32'h0000_002C, 8'h20};
    vec[3]  = '{3'd4, 32'h0000_000F, 3'd4, 32'h0000_0000, 8'h2F};
    vec[4]  = '{3'd5, 32'h0000_0081, 3'd5, 32'h0000_0000, 8'h2E};
    vec[5]  = '{3'd6, 32'h0000_00FF, 3'd6, 32'h0000_0000, 8'h2E};
    vec[6]  = '{3'd7, 32'h0000_00FF, 3'd1, 32'h0000_00F0, 8'h2E};
    vec[7]  = '{3'd3, 32'h0000_00FF, 3'd3, 32'h0000_0000, 8'h2E};
    vec[8]  = '{3'd2, 32'h0000_0001, 3'd2, 32'h0000_0001, 8'h2E};
    vec[9]  = '{3'd1, 32'h0000_00FF, 3'd0, 32'h0000_002E, 8'h2E};
    vec[10] = '{3'd1, 32'h0000_0000, 3'd0, 32'h0000_003C, 8'h2E};
    vec[11] = '{3'd1, 32'hABCD_EF0F, 3'd1, 32'h0000_000F, 8'h2E};
    vec[12] = '{3'd1, 32'h0000_0000, 3'd7, 32'h0000_0000, 8'h2E};
    for (int i = 0; i < 13; i++) begin
      wr(vec[i].wa, vec[i].wd);
      if (i == 0) check("out_en_f0", 32'(out_en), 32'hF0);
      tick(2);
      rd(vec[i].ra, r);
      check($sformatf("vec%0d_read", i), r, vec[i].er);
      check($sformatf("vec%0d_out", i), 32'(out_port), 32'(vec[i].eo));
    end
    check("irq_idle", 32'(irq), 0);

    in_port = 8'h3D;
    tick(2);
    check("rise_not_yet", 32'(irq), 0);
    tick(1);
    check("rise_irq", 32'(irq), 1);
    rd(3, r);
    check("rise_edge", r, 1);
    wr(3, 1);
    check("w1c_irq", 32'(irq), 0);
    in_port = 8'h3C;
    tick(5);
    check("fall_irq", 32'(irq), 0);
    rd(3, r);
    check("fall_edge", r, 0);

    in_port = 8'h3D;
    tick(5);
    check("re_rise_irq", 32'(irq), 1);
    in_port = 8'h3C;
    tick(5);
    in_port = 8'h3D;
    tick(2);
    wr(3, 1);
    check("simul_irq", 32'(irq), 1);
    rd(3, r);
    check("simul_edge", r, 1);

    wr(2, 8'hFF);
    in_port = 8'hC2;
    tick(5);
    in_port = 8'h3D;
    tick(5);
    rd(3, r);
    check("all_edge", r, 32'hFF);
    check("all_irq", 32'(irq), 1);
    wr(6, 0);
    wr(7, 0);
    rd(3, r);
    check("ign67_edge", r, 32'hFF);
    rd(2, r);
    check("ign67_mask", r, 32'hFF);
    reset = 1;
    tick(1);
    reset = 0;
    check("mid_rst_irq", 32'(irq), 0);
    check("mid_rst_readdata", bus.readdata, 0);
    check("mid_rst_out", 32'(out_port), 0);
    rd(3, r);
    check("mid_rst_edge", r, 0);
    rd(2, r);
    check("mid_rst_mask", r, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
